// File: rtl/mux_scan_sequencer.sv
// Scans a 4:1 mux through channels 0..3, samples its output after a settle time on
// each channel and offers the packed 4-bit frame on a valid/ready port.
// Optional build macro MUX_SCAN_PARITY_EN adds a registered even-parity output frame_parity.

module mux_scan_sequencer #(
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       continuous,
    output logic [1:0] sel,
    input  logic       mux_y,
    output logic [3:0] frame,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       busy,
`ifdef MUX_SCAN_PARITY_EN
    output logic       frame_parity,
`endif
    output logic [1:0] state_dbg
);

    // Handshake: a frame transfers on any rising edge where frame_valid && frame_ready.
    // Once raised, frame_valid stays high and frame stays stable until that transfer.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYC - 1);

    state_t           state;
    logic [1:0]       ch;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       samp_buf;

    // The channel register directly drives the mux select, so sel only moves
    // when ch is loaded.
    assign sel       = ch;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ch          <= 2'd0;
            cnt         <= '0;
            samp_buf    <= 3'd0;
            frame       <= 4'd0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            frame_parity <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SETTLE;
                        ch    <= 2'd0;
                        cnt   <= RELOAD;
                        busy  <= 1'b1;
                    end
                end

                SETTLE: begin
                    if (cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                SAMPLE: begin
                    if (ch != 2'd3) begin
                        samp_buf[ch] <= mux_y;
                        ch           <= ch + 2'd1;
                        cnt          <= RELOAD;
                        state        <= SETTLE;
                    end else begin
                        // Last channel goes straight into the frame, not via samp_buf.
                        frame       <= {mux_y, samp_buf};
                        frame_valid <= 1'b1;
                        state       <= HOLD;
`ifdef MUX_SCAN_PARITY_EN
                        frame_parity <= ^{mux_y, samp_buf};
`endif
                    end
                end

                HOLD: begin
                    if (frame_ready) begin
                        frame_valid <= 1'b0;
                        ch          <= 2'd0;
                        if (continuous) begin
                            cnt   <= RELOAD;
                            state <= SETTLE;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: a behavioural 4:1 mux feeds mux_y from sel,
// and hand-computed frames and edge counts are checked against the DUT outputs.

module tb_mux_scan_sequencer;

    localparam int SETTLE_CYC = 2;
    // Edges from the edge that loads SETTLE for channel 0 to the edge that raises frame_valid.
    localparam int SCAN_EDGES = 4 * (SETTLE_CYC + 1);

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       continuous;
    logic [1:0] sel;
    logic       mux_y;
    logic [3:0] frame;
    logic       frame_valid;
    logic       frame_ready;
    logic       busy;
    logic [1:0] state_dbg;
    logic [3:0] mux_in;
`ifdef MUX_SCAN_PARITY_EN
    logic       frame_parity;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Behavioural model of the upstream mux.
    assign mux_y = mux_in[sel];

    mux_scan_sequencer #(.SETTLE_CYC(SETTLE_CYC), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .continuous  (continuous),
        .sel         (sel),
        .mux_y       (mux_y),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .busy        (busy),
`ifdef MUX_SCAN_PARITY_EN
        .frame_parity(frame_parity),
`endif
        .state_dbg   (state_dbg)
    );

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (frame_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("valid_seen", {31'd0, frame_valid}, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_sel"},   {30'd0, sel},         32'd0);
        check({tag, "_frame"}, {28'd0, frame},       32'd0);
        check({tag, "_valid"}, {31'd0, frame_valid}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy},        32'd0);
        check({tag, "_state"}, {30'd0, state_dbg},   32'd0);
`ifdef MUX_SCAN_PARITY_EN
        check({tag, "_parity"}, {31'd0, frame_parity}, 32'd0);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  n;
        logic seen;

        rst         = 1'b1;
        start       = 1'b0;
        continuous  = 1'b0;
        frame_ready = 1'b0;
        mux_in      = 4'b0000;

        // Reset held 3 cycles.
        repeat (3) tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Single scan; also exercises start while busy, ready high outside HOLD and
        // continuous toggling mid-scan (only its handshake-cycle value counts).
        mux_in      = 4'b1010;
        frame_ready = 1'b1;
        pulse_start();
        for (int e = 0; e < SCAN_EDGES; e++) begin
            if (e == 3) continuous = 1'b1;
            if (e == 5) start = 1'b1;
            if (e == 6) start = 1'b0;
            if (e == 9) continuous = 1'b0;
            check($sformatf("scan_sel_e%0d", e), {30'd0, sel}, e / 3);
            check($sformatf("scan_valid_e%0d", e), {31'd0, frame_valid}, 32'd0);
            check($sformatf("scan_busy_e%0d", e), {31'd0, busy}, 32'd1);
            tick();
        end
        check("scan_valid_rise", {31'd0, frame_valid}, 32'd1);
        check("scan_frame", {28'd0, frame}, 32'h0000000a);
        check("scan_hold_sel", {30'd0, sel}, 32'd3);
        tick();
        check("scan_valid_fall", {31'd0, frame_valid}, 32'd0);
        check("scan_idle_busy", {31'd0, busy}, 32'd0);
        check("scan_idle_sel", {30'd0, sel}, 32'd0);
        repeat (3) tick();
        check("scan_no_queued_start", {31'd0, busy}, 32'd0);

        // Backpressure: consumer stalls 20 cycles, mux input changes are ignored.
        mux_in      = 4'b0110;
        frame_ready = 1'b0;
        pulse_start();
        wait_valid(n);
        check("bp_latency", n, SCAN_EDGES);
        for (int c = 0; c < 20; c++) begin
            mux_in = 4'($urandom_range(0, 15));
            tick();
            check($sformatf("bp_frame_c%0d", c), {28'd0, frame}, 32'h00000006);
            check($sformatf("bp_sel_c%0d", c), {30'd0, sel}, 32'd3);
            check($sformatf("bp_busy_c%0d", c), {31'd0, busy}, 32'd1);
            check($sformatf("bp_valid_c%0d", c), {31'd0, frame_valid}, 32'd1);
        end
        frame_ready = 1'b1;
        tick();
        check("bp_valid_fall", {31'd0, frame_valid}, 32'd0);
        check("bp_idle_busy", {31'd0, busy}, 32'd0);

        // Continuous: the handshake edge reloads channel 0, so the next frame_valid
        // rises SCAN_EDGES edges after it, just like from a start edge.
        mux_in     = 4'b0001;
        continuous = 1'b1;
        pulse_start();
        wait_valid(n);
        check("cont_latency", n, SCAN_EDGES);
        check("cont_frame0", {28'd0, frame}, 32'h00000001);
        mux_in = 4'b1000;
        tick();
        check("cont_valid_fall", {31'd0, frame_valid}, 32'd0);
        check("cont_busy", {31'd0, busy}, 32'd1);
        check("cont_sel_back0", {30'd0, sel}, 32'd0);
        wait_valid(n);
        check("cont_period", n, SCAN_EDGES);
        check("cont_frame1", {28'd0, frame}, 32'h00000008);
        continuous = 1'b0;
        tick();
        check("cont_stop_busy", {31'd0, busy}, 32'd0);
        check("cont_stop_valid", {31'd0, frame_valid}, 32'd0);

        // Abort: reset while sel==2 discards the partial frame.
        mux_in = 4'b1111;
        pulse_start();
        n = 0;
        while (sel !== 2'd2 && n < 50) begin
            tick();
            n++;
        end
        check("abort_reach_sel2", {30'd0, sel}, 32'd2);
        rst = 1'b1;
        tick();
        check_reset_values("abort");
        rst  = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            seen |= frame_valid;
        end
        check("abort_never_valid", {31'd0, seen}, 32'd0);

        // start and rst together: reset wins.
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_busy", {31'd0, busy}, 32'd0);
        check("rst_start_state", {30'd0, state_dbg}, 32'd0);

`ifdef MUX_SCAN_PARITY_EN
        mux_in = 4'b0111;
        pulse_start();
        wait_valid(n);
        check("par_frame", {28'd0, frame}, 32'h00000007);
        check("par_bit", {31'd0, frame_parity}, 32'd1);
        tick();
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
